// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between the ALU reservation station
// and the load/store buffer. Each source writes into a private FIFO, and a
// round-robin arbiter drains one entry per cycle onto a registered CDB.
module cdb_arbiter #(
    parameter int ROB_ID_W = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic                alu_valid,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [DATA_W-1:0]   alu_value,
    input  logic                alu_jump,
    input  logic [ADDR_W-1:0]   alu_pc_next,
    output logic                alu_full,
    input  logic                lsb_valid,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    input  logic [DATA_W-1:0]   lsb_value,
    output logic                lsb_full,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [DATA_W-1:0]   cdb_value,
    output logic                cdb_jump,
    output logic [ADDR_W-1:0]   cdb_pc_next,
    output logic                cdb_src
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSB = 1'b1;

    // ALU queue storage and pointers
    logic [ROB_ID_W-1:0] alu_id_mem   [DEPTH];
    logic [DATA_W-1:0]   alu_val_mem  [DEPTH];
    logic                alu_jump_mem [DEPTH];
    logic [ADDR_W-1:0]   alu_pc_mem   [DEPTH];
    logic [PTR_W-1:0]    alu_wr_ptr;
    logic [PTR_W-1:0]    alu_rd_ptr;
    logic [CNT_W-1:0]    alu_cnt;

    // LSB queue storage and pointers (no jump / next-PC fields)
    logic [ROB_ID_W-1:0] lsb_id_mem  [DEPTH];
    logic [DATA_W-1:0]   lsb_val_mem [DEPTH];
    logic [PTR_W-1:0]    lsb_wr_ptr;
    logic [PTR_W-1:0]    lsb_rd_ptr;
    logic [CNT_W-1:0]    lsb_cnt;

    logic last_grant;
    logic alu_push;
    logic lsb_push;
    logic alu_nonempty;
    logic lsb_nonempty;
    logic grant_alu;
    logic grant_lsb;

    // Full flags, push acceptance and round-robin grant from registered state
    always_comb begin
        alu_full     = (alu_cnt == FULL_CNT);
        lsb_full     = (lsb_cnt == FULL_CNT);
        alu_push     = alu_valid && !alu_full;
        lsb_push     = lsb_valid && !lsb_full;
        alu_nonempty = (alu_cnt != '0);
        lsb_nonempty = (lsb_cnt != '0);
        grant_alu    = alu_nonempty && (!lsb_nonempty || (last_grant == SRC_LSB));
        grant_lsb    = lsb_nonempty && (!alu_nonempty || (last_grant == SRC_ALU));
    end

    // Queue payload writes; storage needs no reset since counts gate reads
    always_ff @(posedge clk) begin
        if (!rst && rdy && !flush) begin
            if (alu_push) begin
                alu_id_mem[alu_wr_ptr]   <= alu_rob_id;
                alu_val_mem[alu_wr_ptr]  <= alu_value;
                alu_jump_mem[alu_wr_ptr] <= alu_jump;
                alu_pc_mem[alu_wr_ptr]   <= alu_pc_next;
            end
            if (lsb_push) begin
                lsb_id_mem[lsb_wr_ptr]  <= lsb_rob_id;
                lsb_val_mem[lsb_wr_ptr] <= lsb_value;
            end
        end
    end

    // ALU queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_wr_ptr <= '0;
            alu_rd_ptr <= '0;
            alu_cnt    <= '0;
        end else if (rdy) begin
            if (flush) begin
                alu_wr_ptr <= '0;
                alu_rd_ptr <= '0;
                alu_cnt    <= '0;
            end else begin
                if (alu_push)
                    alu_wr_ptr <= alu_wr_ptr + 1'b1;
                if (grant_alu)
                    alu_rd_ptr <= alu_rd_ptr + 1'b1;
                case ({alu_push, grant_alu})
                    2'b10:   alu_cnt <= alu_cnt + 1'b1;
                    2'b01:   alu_cnt <= alu_cnt - 1'b1;
                    default: alu_cnt <= alu_cnt;
                endcase
            end
        end
    end

    // LSB queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            lsb_wr_ptr <= '0;
            lsb_rd_ptr <= '0;
            lsb_cnt    <= '0;
        end else if (rdy) begin
            if (flush) begin
                lsb_wr_ptr <= '0;
                lsb_rd_ptr <= '0;
                lsb_cnt    <= '0;
            end else begin
                if (lsb_push)
                    lsb_wr_ptr <= lsb_wr_ptr + 1'b1;
                if (grant_lsb)
                    lsb_rd_ptr <= lsb_rd_ptr + 1'b1;
                case ({lsb_push, grant_lsb})
                    2'b10:   lsb_cnt <= lsb_cnt + 1'b1;
                    2'b01:   lsb_cnt <= lsb_cnt - 1'b1;
                    default: lsb_cnt <= lsb_cnt;
                endcase
            end
        end
    end

    // Registered CDB broadcast and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= SRC_LSB;
            cdb_valid   <= 1'b0;
            cdb_rob_id  <= '0;
            cdb_value   <= '0;
            cdb_jump    <= 1'b0;
            cdb_pc_next <= '0;
            cdb_src     <= SRC_ALU;
        end else if (rdy) begin
            if (flush) begin
                cdb_valid  <= 1'b0;
                last_grant <= SRC_LSB;
            end else begin
                cdb_valid <= grant_alu || grant_lsb;
                if (grant_alu) begin
                    last_grant  <= SRC_ALU;
                    cdb_src     <= SRC_ALU;
                    cdb_rob_id  <= alu_id_mem[alu_rd_ptr];
                    cdb_value   <= alu_val_mem[alu_rd_ptr];
                    cdb_jump    <= alu_jump_mem[alu_rd_ptr];
                    cdb_pc_next <= alu_pc_mem[alu_rd_ptr];
                end else if (grant_lsb) begin
                    last_grant  <= SRC_LSB;
                    cdb_src     <= SRC_LSB;
                    cdb_rob_id  <= lsb_id_mem[lsb_rd_ptr];
                    cdb_value   <= lsb_val_mem[lsb_rd_ptr];
                    cdb_jump    <= 1'b0;
                    cdb_pc_next <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: scenario tasks drive stimulus and push expected
// broadcasts into per-source scoreboard queues; a monitor process pops and
// compares whenever the CDB carries a broadcast that is consumed.
module tb_cdb_arbiter;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] value;
        logic        jump;
        logic [31:0] pc;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        alu_valid;
    logic [3:0]  alu_rob_id;
    logic [31:0] alu_value;
    logic        alu_jump;
    logic [31:0] alu_pc_next;
    logic        alu_full;
    logic        lsb_valid;
    logic [3:0]  lsb_rob_id;
    logic [31:0] lsb_value;
    logic        lsb_full;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_value;
    logic        cdb_jump;
    logic [31:0] cdb_pc_next;
    logic        cdb_src;

    int errors;
    int checks;

    ent_t       exp_alu[$];
    ent_t       exp_lsb[$];
    logic       seen_src[$];
    logic [3:0] seen_id[$];

    cdb_arbiter #(
        .ROB_ID_W(4),
        .DATA_W  (32),
        .ADDR_W  (32),
        .DEPTH   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .flush      (flush),
        .alu_valid  (alu_valid),
        .alu_rob_id (alu_rob_id),
        .alu_value  (alu_value),
        .alu_jump   (alu_jump),
        .alu_pc_next(alu_pc_next),
        .alu_full   (alu_full),
        .lsb_valid  (lsb_valid),
        .lsb_rob_id (lsb_rob_id),
        .lsb_value  (lsb_value),
        .lsb_full   (lsb_full),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value),
        .cdb_jump   (cdb_jump),
        .cdb_pc_next(cdb_pc_next),
        .cdb_src    (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic [3:0] id, input logic [31:0] val,
                             input logic jmp, input logic [31:0] pc, input bit expect_it);
        alu_valid   = 1'b1;
        alu_rob_id  = id;
        alu_value   = val;
        alu_jump    = jmp;
        alu_pc_next = pc;
        if (expect_it) exp_alu.push_back('{id: id, value: val, jump: jmp, pc: pc});
    endtask

    task automatic drive_lsb(input logic [3:0] id, input logic [31:0] val, input bit expect_it);
        lsb_valid  = 1'b1;
        lsb_rob_id = id;
        lsb_value  = val;
        if (expect_it) exp_lsb.push_back('{id: id, value: val, jump: 1'b0, pc: 32'h0});
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        lsb_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_alu.delete();
        exp_lsb.delete();
        seen_src.delete();
        seen_id.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdy = 1'b1;
        flush = 1'b0;
        drive_alu(4'd7, 32'hFFFF_0000, 1'b1, 32'h8000, 1'b0);
        drive_lsb(4'd9, 32'h1111_2222, 1'b0);
        tick();
        tick();
        checks++;
        if ({cdb_valid, cdb_rob_id, cdb_value, cdb_jump, cdb_pc_next, cdb_src} !== '0) begin
            errors++;
            $display("FAIL reset_cdb: got valid=%b id=%0d value=%h jump=%b pc=%h src=%b, required all 0",
                     cdb_valid, cdb_rob_id, cdb_value, cdb_jump, cdb_pc_next, cdb_src);
        end
        checks++;
        if ({alu_full, lsb_full} !== 2'b00) begin
            errors++;
            $display("FAIL reset_full: got alu_full=%b lsb_full=%b, required 0 0", alu_full, lsb_full);
        end
        rst = 1'b0;
        idle();
        tick();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_inputs_ignored: got cdb_valid=%b, required 0", cdb_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        drive_alu(4'd3, 32'h1234_5678, 1'b1, 32'h1004, 1'b1);
        tick();
        idle();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got cdb_valid=%b after edge 1, required 0", cdb_valid);
        end
        tick();
        checks++;
        if ({cdb_valid, cdb_rob_id, cdb_value, cdb_jump, cdb_pc_next, cdb_src} !==
            {1'b1, 4'd3, 32'h1234_5678, 1'b1, 32'h1004, 1'b0}) begin
            errors++;
            $display("FAIL single_bcast: got valid=%b id=%0d value=%h jump=%b pc=%h src=%b, required 1 3 12345678 1 00001004 0",
                     cdb_valid, cdb_rob_id, cdb_value, cdb_jump, cdb_pc_next, cdb_src);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_one_cycle: got cdb_valid=%b, required 0", cdb_valid);
        end
    endtask

    task automatic test_tie();
        do_reset();
        drive_alu(4'd1, 32'hA, 1'b1, 32'h20, 1'b1);
        drive_lsb(4'd2, 32'hB, 1'b1);
        tick();
        idle();
        tick();
        checks++;
        if ({cdb_valid, cdb_rob_id, cdb_src} !== {1'b1, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL tie_first: got valid=%b id=%0d src=%b, required 1 1 0", cdb_valid, cdb_rob_id, cdb_src);
        end
        tick();
        checks++;
        if ({cdb_valid, cdb_rob_id, cdb_value, cdb_src, cdb_jump, cdb_pc_next} !==
            {1'b1, 4'd2, 32'hB, 1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL tie_second: got valid=%b id=%0d value=%h src=%b jump=%b pc=%h, required 1 2 0000000b 1 0 00000000",
                     cdb_valid, cdb_rob_id, cdb_value, cdb_src, cdb_jump, cdb_pc_next);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL tie_idle: got cdb_valid=%b, required 0", cdb_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] order [4];
        order[0] = 4'd4; order[1] = 4'd6; order[2] = 4'd5; order[3] = 4'd7;
        do_reset();
        drive_alu(4'd4, 32'h40, 1'b0, 32'h400, 1'b1);
        drive_lsb(4'd6, 32'h60, 1'b1);
        tick();
        drive_alu(4'd5, 32'h50, 1'b1, 32'h500, 1'b1);
        drive_lsb(4'd7, 32'h70, 1'b1);
        tick();
        checks++;
        if ({lsb_full, alu_full} !== 2'b10) begin
            errors++;
            $display("FAIL bp_full: got lsb_full=%b alu_full=%b, required 1 0", lsb_full, alu_full);
        end
        // LSB push while full must be dropped
        alu_valid = 1'b0;
        drive_lsb(4'd13, 32'hD0, 1'b0);
        for (int unsigned i = 0; i < 4; i++) begin
            checks++;
            if ({cdb_valid, cdb_rob_id} !== {1'b1, order[i]}) begin
                errors++;
                $display("FAIL bp_order[%0d]: got valid=%b id=%0d, required 1 %0d", i, cdb_valid, cdb_rob_id, order[i]);
            end
            tick();
            idle();
        end
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drop_when_full: got cdb_valid=%b id=%0d, required 0", cdb_valid, cdb_rob_id);
        end
    endtask

    task automatic test_round_robin();
        int n_push;
        int bad_alt;
        logic [3:0] alu_id;
        logic [3:0] lsb_id;
        do_reset();
        n_push = 0;
        alu_id = 4'd0;
        lsb_id = 4'd8;
        for (int unsigned c = 0; c < 20; c++) begin
            if (!alu_full) begin
                drive_alu(alu_id, 32'hA000_0000 + c, c[0], 32'h100 + c, 1'b1);
                alu_id = alu_id + 4'd1;
                n_push++;
            end else begin
                alu_valid = 1'b0;
            end
            if (!lsb_full) begin
                drive_lsb(lsb_id, 32'hB000_0000 + c, 1'b1);
                lsb_id = lsb_id + 4'd1;
                n_push++;
            end else begin
                lsb_valid = 1'b0;
            end
            tick();
        end
        idle();
        for (int unsigned c = 0; c < 8; c++) tick();
        bad_alt = 0;
        for (int i = 1; i < seen_src.size(); i++)
            if (seen_src[i] === seen_src[i-1]) bad_alt++;
        checks++;
        if (bad_alt != 0) begin
            errors++;
            $display("FAIL rr_alternate: got %0d repeated-source broadcasts, required 0", bad_alt);
        end
        checks++;
        if (seen_src.size() != n_push) begin
            errors++;
            $display("FAIL rr_count: got %0d broadcasts, required %0d", seen_src.size(), n_push);
        end
        checks++;
        if (exp_alu.size() + exp_lsb.size() != 0) begin
            errors++;
            $display("FAIL rr_lost: got %0d entries never broadcast, required 0", exp_alu.size() + exp_lsb.size());
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive_alu(4'd8, 32'h88, 1'b1, 32'h800, 1'b1);
        drive_lsb(4'd10, 32'hAA, 1'b1);
        tick();
        lsb_valid = 1'b0;
        drive_alu(4'd9, 32'h99, 1'b0, 32'h900, 1'b1);
        tick();
        checks++;
        if ({cdb_valid, cdb_rob_id, cdb_src} !== {1'b1, 4'd8, 1'b0}) begin
            errors++;
            $display("FAIL flush_pre: got valid=%b id=%0d src=%b, required 1 8 0", cdb_valid, cdb_rob_id, cdb_src);
        end
        flush = 1'b1;
        drive_alu(4'd14, 32'hEE, 1'b1, 32'hE00, 1'b0);
        drive_lsb(4'd15, 32'hFF, 1'b0);
        tick();
        flush = 1'b0;
        idle();
        checks++;
        if ({cdb_valid, alu_full, lsb_full, cdb_rob_id, cdb_value} !== {3'b000, 4'd8, 32'h88}) begin
            errors++;
            $display("FAIL flush_state: got valid=%b alu_full=%b lsb_full=%b id=%0d value=%h, required 0 0 0 8 00000088",
                     cdb_valid, alu_full, lsb_full, cdb_rob_id, cdb_value);
        end
        checks++;
        if (exp_alu.size() != 1 || exp_lsb.size() != 1) begin
            errors++;
            $display("FAIL flush_pending: got alu=%0d lsb=%0d outstanding, required 1 1", exp_alu.size(), exp_lsb.size());
        end
        exp_alu.delete();
        exp_lsb.delete();
        for (int unsigned c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_quiet[%0d]: got cdb_valid=%b id=%0d, required 0", c, cdb_valid, cdb_rob_id);
            end
        end
        drive_alu(4'd1, 32'h11, 1'b0, 32'h10, 1'b1);
        drive_lsb(4'd2, 32'h22, 1'b1);
        tick();
        idle();
        tick();
        checks++;
        if ({cdb_valid, cdb_rob_id, cdb_src} !== {1'b1, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL flush_tie: got valid=%b id=%0d src=%b, required 1 1 0", cdb_valid, cdb_rob_id, cdb_src);
        end
        tick();
        tick();
    endtask

    task automatic test_stall();
        logic [3:0] order [3];
        order[0] = 4'd5; order[1] = 4'd11; order[2] = 4'd12;
        do_reset();
        drive_alu(4'd5, 32'h55, 1'b0, 32'h100, 1'b1);
        drive_lsb(4'd11, 32'hBB, 1'b1);
        tick();
        lsb_valid = 1'b0;
        drive_alu(4'd12, 32'hCC, 1'b1, 32'h200, 1'b1);
        tick();
        checks++;
        if ({cdb_valid, cdb_rob_id} !== {1'b1, 4'd5}) begin
            errors++;
            $display("FAIL stall_setup: got valid=%b id=%0d, required 1 5", cdb_valid, cdb_rob_id);
        end
        rdy = 1'b0;
        drive_alu(4'd14, 32'hDEAD, 1'b1, 32'hBAD0, 1'b0);
        drive_lsb(4'd15, 32'hBEEF, 1'b0);
        for (int unsigned c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({cdb_valid, cdb_rob_id, cdb_value, cdb_src, alu_full, lsb_full} !==
                {1'b1, 4'd5, 32'h55, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b id=%0d value=%h src=%b alu_full=%b lsb_full=%b, required 1 5 00000055 0 0 0",
                         c, cdb_valid, cdb_rob_id, cdb_value, cdb_src, alu_full, lsb_full);
            end
        end
        rdy = 1'b1;
        idle();
        for (int unsigned c = 0; c < 5; c++) tick();
        checks++;
        if (seen_id.size() != 3) begin
            errors++;
            $display("FAIL stall_count: got %0d broadcasts, required 3", seen_id.size());
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                checks++;
                if (seen_id[i] !== order[i]) begin
                    errors++;
                    $display("FAIL stall_order[%0d]: got id=%0d, required %0d", i, seen_id[i], order[i]);
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        rdy = 1'b1;
        flush = 1'b0;
        alu_valid = 1'b0;
        alu_rob_id = '0;
        alu_value = '0;
        alu_jump = 1'b0;
        alu_pc_next = '0;
        lsb_valid = 1'b0;
        lsb_rob_id = '0;
        lsb_value = '0;

        // Scoreboard monitor: a broadcast is consumed at the edge where rdy is high
        fork
            forever begin
                ent_t obs;
                ent_t exp_e;
                @(negedge clk);
                if (!rst && rdy && cdb_valid) begin
                    obs = {cdb_rob_id, cdb_value, cdb_jump, cdb_pc_next};
                    seen_src.push_back(cdb_src);
                    seen_id.push_back(cdb_rob_id);
                    checks++;
                    if (cdb_src === 1'b0 && exp_alu.size() > 0) begin
                        exp_e = exp_alu.pop_front();
                        if (obs !== exp_e) begin
                            errors++;
                            $display("FAIL sb_alu: got id=%0d value=%h jump=%b pc=%h, required id=%0d value=%h jump=%b pc=%h",
                                     obs.id, obs.value, obs.jump, obs.pc, exp_e.id, exp_e.value, exp_e.jump, exp_e.pc);
                        end
                    end else if (cdb_src === 1'b1 && exp_lsb.size() > 0) begin
                        exp_e = exp_lsb.pop_front();
                        if (obs !== exp_e) begin
                            errors++;
                            $display("FAIL sb_lsb: got id=%0d value=%h jump=%b pc=%h, required id=%0d value=%h jump=0 pc=0",
                                     obs.id, obs.value, obs.jump, obs.pc, exp_e.id, exp_e.value);
                        end
                    end else begin
                        errors++;
                        $display("FAIL sb_unexpected: got src=%b id=%0d value=%h, required no broadcast",
                                 cdb_src, cdb_rob_id, cdb_value);
                    end
                end
            end
        join_none

        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_round_robin();
        test_flush();
        test_stall();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
